ddr_serialiser: RTL

DDR_SERIALISER -- requirements
Module: ddr_serialiser

---
 rtl/ddr_serialiser.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ddr_serialiser.sv
// Word-to-DDR-pair serialiser with forwarded clock and frame select; MSB pair first.
// Optional sticky underrun flag is built only when DDR_SERIALISER_UNDERRUN_EN is defined.
module ddr_serialiser #(
  parameter int W          = 16,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         dp,
  output logic         dn,
  output logic         sck_dp,
  output logic         sck_dn,
  output logic         cs_n,
  output logic         underrun,
  input  logic         underrun_clr
);

  localparam int P  = W / 2;
  localparam int CW = (P > 1) ? $clog2(P) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_STALL, S_HOLD} state_t;

  state_t         state_q;
  logic [W-1:0]   sh_q;
  logic           last_q;
  logic [CW-1:0]  cnt_q;
  logic           dp_q, dn_q, sck_dp_q, sck_dn_q, cs_n_q;
  logic           final_pair;

  assign final_pair = (state_q == S_SHIFT) && (cnt_q == '0);
  // Ready comes from state only, never from in_valid.
  assign in_ready   = (state_q == S_IDLE) || (state_q == S_STALL) || (final_pair && !last_q);

  assign dp     = dp_q;
  assign dn     = dn_q;
  assign sck_dp = sck_dp_q;
  assign sck_dn = sck_dn_q;
  assign cs_n   = cs_n_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sh_q     <= '0;
      last_q   <= 1'b0;
      cnt_q    <= '0;
      dp_q     <= IDLE_LEVEL;
      dn_q     <= IDLE_LEVEL;
      sck_dp_q <= 1'b0;
      sck_dn_q <= 1'b0;
      cs_n_q   <= 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            sh_q    <= in_data;
            last_q  <= in_last;
            cs_n_q  <= 1'b0;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          dp_q     <= sh_q[W-1];
          dn_q     <= sh_q[W-2];
          sh_q     <= sh_q << 2;
          cnt_q    <= CW'(P - 1);
          sck_dn_q <= 1'b1;
          state_q  <= S_SHIFT;
        end
        S_SHIFT: begin
          if (cnt_q != '0) begin
            dp_q  <= sh_q[W-1];
            dn_q  <= sh_q[W-2];
            sh_q  <= sh_q << 2;
            cnt_q <= cnt_q - 1'b1;
          end else if (last_q) begin
            dp_q     <= IDLE_LEVEL;
            dn_q     <= IDLE_LEVEL;
            sck_dn_q <= 1'b0;
            state_q  <= S_HOLD;
          end else if (in_valid) begin
            // Gapless reload: the new word's first pair goes straight out.
            dp_q   <= in_data[W-1];
            dn_q   <= in_data[W-2];
            sh_q   <= in_data << 2;
            last_q <= in_last;
            cnt_q  <= CW'(P - 1);
          end else begin
            dp_q     <= IDLE_LEVEL;
            dn_q     <= IDLE_LEVEL;
            sck_dn_q <= 1'b0;
            state_q  <= S_STALL;
          end
        end
        S_STALL: begin
          if (in_valid) begin
            dp_q     <= in_data[W-1];
            dn_q     <= in_data[W-2];
            sh_q     <= in_data << 2;
            last_q   <= in_last;
            cnt_q    <= CW'(P - 1);
            sck_dn_q <= 1'b1;
            state_q  <= S_SHIFT;
          end
        end
        S_HOLD: begin
          cs_n_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          cs_n_q  <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef DDR_SERIALISER_UNDERRUN_EN
  logic underrun_q;
  logic ur_set;

  assign ur_set = final_pair && !last_q && !in_valid;

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)               underrun_q <= 1'b0;
    else if (ur_set)       underrun_q <= 1'b1;
    else if (underrun_clr) underrun_q <= 1'b0;
  end

  assign underrun = underrun_q;
`else
  logic unused_clr;
  assign unused_clr = underrun_clr;
  assign underrun   = 1'b0;
`endif

endmodule
